imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the RISC core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them to consecutive 10-bit instruction-memory addresses from 0, holding the core in reset until the whole program is written. It replaces the fixed memory image used in simulation and is the producer side of the instruction-fetch read path.

## Interface

Parameters:
- ADDR_W, 10, instruction-memory word-address width (matches PC width)
- DATA_W, 32, instruction word width
- MAX_WORDS, 1024, largest legal program length (2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a new load
- in_valid  input  1  byte present on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction-memory write enable, one cycle per word
- imem_addr  output  ADDR_W  word address for the write
- imem_wdata  output  DATA_W  instruction word for the write
- core_reset  output  1  holds the RISC core in reset while high
- done  output  1  program loaded; core released
- err  output  1  illegal length header received

## Operation

- Stream format: 2-byte big-endian word count N, then 4·N bytes, each word most-significant byte first.
- A byte transfers on a rising edge with in_valid && in_ready. in_data must be stable while in_valid is high and in_ready is low.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- IDLE: in_ready=0, core_reset=1. start moves to LEN_HI.
- LEN_HI / LEN_LO: in_ready=1. Capture count[15:8] and count[7:0].
  - After LEN_LO, if N==0 or N>MAX_WORDS, go to ERR.
  - Otherwise clear the word index and byte counter, then go to DATA.
- DATA: in_ready=1. Shift bytes into the word register. On the 4th accepted byte, go to WRITE.
- WRITE, one cycle:
  - imem_we=1, imem_addr=word index, imem_wdata=assembled word, in_ready=0.
  - Then increment the word index.
  - If this was word N−1, go to DONE; otherwise return to DATA.
- DONE: core_reset=0, done=1, in_ready=0. start returns to LEN_HI, re-asserts core_reset and clears done.
- ERR: err=1, core_reset=1, in_ready=0. start clears err and goes to LEN_HI.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- Width rules:
  - The word index is ADDR_W+1 bits and is compared against N−1.
  - N=1024 ends at address 0x3FF and never wraps.
  - imem_addr is the low ADDR_W bits of the index.

## Timing

- All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- Reset values (asynchronous, immediate):
  - state=IDLE, core_reset=1, done=0, err=0, in_ready=0
  - imem_we=0, imem_addr=0, imem_wdata=0
  - count, index and byte counter all 0
- Write latency: imem_we is high for exactly the cycle after the edge that accepted a word's 4th byte.
- in_ready drops for that single cycle, so the peak rate is 4 bytes per 5 cycles.
- Release: the edge after the final WRITE cycle enters DONE. core_reset falls and done rises on that edge.
- start in DONE or ERR: LEN_HI, core_reset=1, done=0 and err=0 all take effect on the same edge.
- Reset mid-load aborts immediately. Words already written stay in memory; nothing further is written.
- imem_addr and imem_wdata hold their last values when imem_we=0.

## Structure

- Shared header risc_defs.vh holds the ADDR_W/DATA_W defaults (shared with PC/IR widths) and the state encodings.
- One sub-module, byte_packer, is the natural split: an 8-to-32 big-endian shift register with a 2-bit byte counter and a word_full pulse.
- The FSM, word index and length check stay in imem_loader.

## Test plan

- Reset held, then released with start low → in_ready=0, core_reset=1, imem_we=0, done=0, err=0, and state stays IDLE.
- start, then bytes 00 02 12 34 56 78 DE AD BE EF → two writes: (0x000, 0x12345678) then (0x001, 0xDEADBEEF); core_reset falls and done=1 on the edge after the second write.
- Same load with in_valid gaps of 0–3 cycles → identical writes. No byte is accepted during WRITE cycles; a byte presented there is taken on the next cycle.
- Header 00 00, and separately header 04 01 → err=1, core_reset=1, no imem_we; a following start clears err and accepts header 00 01 plus one word.
- reset pulsed after 3 data bytes of the first word → outputs return to reset values at once with no write; a new start plus a full stream loads correctly from address 0.
- Header 04 00 with 1024 words (word k = k) → last write is (0x3FF, 0x000003FF); then start in DONE re-asserts core_reset on the next edge.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// ADDR_W/DATA_W defaults track the PC and IR widths of the core.
package imem_loader_pkg;

    localparam int unsigned ADDR_W_DEF    = 10;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned MAX_WORDS_DEF = 1024;
    localparam int unsigned LEN_W         = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // A program must hold at least one word and fit the memory.
    function automatic logic len_ok(input logic [LEN_W-1:0] n,
                                    input logic [LEN_W-1:0] max_n);
        return (n != '0) && (n <= max_n);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word shift register; word_full flags the byte
// that completes a word, with word_next carrying the finished word.
module imem_loader_byte_packer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word_next,
    output logic              word_full
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_W-9:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign word_next = {acc_q, byte_in};
    assign word_full = shift_en && (cnt_q == CNT_W'(BYTES - 1));

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (shift_en) begin
            acc_d = word_next[DATA_W-9:0];
            cnt_d = word_full ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a length-prefixed byte stream,
// writes words from address 0 and releases the core once the program is in.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_WORDS);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic               accept;
    logic               last_word;
    logic [LEN_W-1:0]   len_new;
    logic               pk_clr;
    logic               pk_shift;
    logic [DATA_W-1:0]  word_next;
    logic               word_full;

    imem_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (pk_clr),
        .shift_en  (pk_shift),
        .byte_in   (in_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    // All outputs come straight from registered state, never from inputs.
    assign in_ready   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA);
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);

    assign accept    = in_valid && in_ready;
    assign len_new   = {count_q[LEN_W-1:8], in_data};
    // Index is one bit wider than the address so N=MAX_WORDS never aliases.
    assign last_word = (LEN_W'(index_q) == (count_q - LEN_W'(1)));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        index_d  = index_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pk_clr   = 1'b0;
        pk_shift = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    count_d[LEN_W-1:8] = in_data;
                    state_d            = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    count_d = len_new;
                    if (len_ok(len_new, MAX_N)) begin
                        index_d = '0;
                        pk_clr  = 1'b1;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    pk_shift = 1'b1;
                    if (word_full) begin
                        addr_d  = index_q[ADDR_W-1:0];
                        wdata_d = word_next;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                index_d = index_q + IDX_W'(1);
                state_d = last_word ? S_DONE : S_DATA;
            end
            S_DONE, S_ERR: begin
                if (start) state_d = S_LEN_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a queue as the
// stream is sent; a negedge monitor pops and compares each imem_we cycle.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.a));
                chk("write_data", imem_wdata, e.d);
            end
            chk("ready_in_write", 32'(in_ready), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_idle(input string name, input bit regs_zero);
        chk({name, "_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_core_reset"}, 32'(core_reset), 32'd1);
        chk({name, "_we"}, 32'(imem_we), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
        if (regs_zero) begin
            chk({name, "_addr"}, 32'(imem_addr), 32'd0);
            chk({name, "_wdata"}, imem_wdata, 32'd0);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int n);
        bit acc;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got no accept expected accept of %0h", b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic load(input bit gapmode);
        int n;
        int nw;
        nw = prog.size();
        send_byte(8'(nw >> 8), 0, n);
        send_byte(8'(nw), 0, n);
        for (int w = 0; w < nw; w++) begin
            exp_t e;
            e.a = 10'(w);
            e.d = prog[w];
            exp_q.push_back(e);
            for (int j = 0; j < 4; j++) begin
                send_byte(prog[w][31-8*j -: 8], gapmode ? j : 0, n);
                // The byte after a word waits out the single WRITE cycle.
                chk("accept_wait", 32'(n), (j == 0 && w > 0) ? 32'd2 : 32'd1);
            end
        end
        @(negedge clk);
        chk("last_we", 32'(imem_we), 32'd1);
        chk("last_core_reset", 32'(core_reset), 32'd1);
        chk("last_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("release_done", 32'(done), 32'd1);
        chk("release_core_reset", 32'(core_reset), 32'd0);
        chk("release_we", 32'(imem_we), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bad_header(input logic [7:0] hi, input logic [7:0] lo);
        int n;
        send_byte(hi, 0, n);
        send_byte(lo, 0, n);
        @(negedge clk);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_core_reset", 32'(core_reset), 32'd1);
        chk("bad_ready", 32'(in_ready), 32'd0);
        chk("bad_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
        chk("err_clear", 32'(err), 32'd0);
        chk("err_restart_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("rst_hold", 1'b1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("post_rst", 1'b1);
        @(posedge clk);
        #1;

        // Basic two-word load.
        pulse_start();
        prog = '{32'h12345678, 32'hDEADBEEF};
        load(1'b0);

        // Restart from DONE, same load with input gaps.
        pulse_start();
        @(negedge clk);
        chk("restart_core_reset", 32'(core_reset), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        load(1'b1);

        // Illegal headers: zero length, then one word too many.
        pulse_start();
        send_bad_header(8'h00, 8'h00);
        send_bad_header(8'h04, 8'h01);
        prog = '{32'hCAFEF00D};
        load(1'b0);

        // Reset in the middle of the first word.
        pulse_start();
        send_byte(8'h00, 0, n);
        send_byte(8'h02, 0, n);
        send_byte(8'h11, 0, n);
        send_byte(8'h22, 0, n);
        send_byte(8'h33, 0, n);
        reset = 1'b1;
        #1;
        check_idle("mid_rst", 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("after_mid_rst", 1'b1);
        @(posedge clk);
        #1;
        pulse_start();
        prog = '{32'hAABBCCDD, 32'h01020304};
        load(1'b0);

        // Full-size program, word k = k.
        pulse_start();
        prog.delete();
        for (int k = 0; k < 1024; k++) prog.push_back(32'(k));
        load(1'b0);
        pulse_start();
        @(negedge clk);
        chk("full_restart_core_reset", 32'(core_reset), 32'd1);
        chk("full_restart_done", 32'(done), 32'd0);
        chk("full_last_addr", 32'(imem_addr), 32'h3FF);
        chk("full_last_data", imem_wdata, 32'h3FF);

        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
